param_queue: RTL and testbench

Parametrised circular FIFO: the next generation of the team's fixed 8×8 queue. Width, depth and watermark thresholds are configurable. It adds an occupancy count, almost-full/almost-empty watermarks, simultaneous enqueue/dequeue, and sticky overflow/underflow error flags. It sits between producer and consumer logic in the same clock domain and keeps the enqueue/dequeue/peek command style of the earlier queue.

---
 rtl/param_queue.sv | 113 +++++++++++
 tb/tb_param_queue.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/param_queue.sv
// param_queue: parametrised same-clock circular FIFO. It provides an occupancy count,
//   almost-full/almost-empty watermarks and sticky overflow/underflow error flags.
// Latency: data_out is registered and is valid 1 cycle after a dequeue or peek is sampled.
//   All status outputs are decoded from registered state.
// Backpressure: none is pushed back. An enqueue to a full queue is dropped and sets overflow,
//   unless a dequeue happens in the same cycle. A dequeue from an empty queue is ignored and
//   sets underflow.
// Ports: clk/rst (async active-low); enqueue/dequeue/peek/clear_err commands; data_in/data_out;
//   count plus is_empty/is_full/almost_full/almost_empty; overflow/underflow sticky errors.
module param_queue #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enqueue,
    input  logic                         dequeue,
    input  logic                         peek,
    input  logic                         clear_err,
    input  logic [WIDTH-1:0]             data_in,
    output logic [WIDTH-1:0]             data_out,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         is_empty,
    output logic                         is_full,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;

    logic do_enq;
    logic do_deq;
    logic do_peek;
    logic ovf_evt;
    logic udf_evt;
    logic [CW-1:0] count_nxt;

    assign is_empty     = (count == '0);
    assign is_full      = (count == FULL_CNT);
    // Thresholds are compared as 32-bit integers, so an out-of-range threshold
    // simply never (or always) matches instead of being truncated.
    assign almost_full  = (int'(count) >= AF_THRESH);
    assign almost_empty = (int'(count) <= AE_THRESH);

    // When the queue is full, a simultaneous pop frees the slot, so the write is accepted.
    // When the queue is empty, there is no bypass: only the write happens.
    assign do_deq  = dequeue && !is_empty;
    assign do_enq  = enqueue && (!is_full || dequeue);
    assign do_peek = peek && !dequeue && !is_empty;
    assign ovf_evt = enqueue && is_full && !dequeue;
    assign udf_evt = dequeue && is_empty;

    always_comb begin
        count_nxt = count;
        case ({do_enq, do_deq})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Storage has no reset; its contents are never observed before they are written.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            mem[tail] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            data_out  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count <= count_nxt;
            if (do_enq) begin
                tail <= (tail == LAST_PTR) ? '0 : tail + PW'(1);
            end
            if (do_deq) begin
                head     <= (head == LAST_PTR) ? '0 : head + PW'(1);
                data_out <= mem[head];
            end else if (do_peek) begin
                data_out <= mem[head];
            end
            // If a new error event occurs in the same cycle as clear_err, the event wins.
            if (ovf_evt) begin
                overflow <= 1'b1;
            end else if (clear_err) begin
                overflow <= 1'b0;
            end
            if (udf_evt) begin
                underflow <= 1'b1;
            end else if (clear_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_param_queue.sv
// Directed bench for param_queue: an 8-deep instance for most scenarios and a
// 5-deep instance for the non-power-of-two pointer wrap.
module tb_param_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       enqueue = 1'b0, dequeue = 1'b0, peek = 1'b0, clear_err = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic [3:0] count;
    logic       is_empty, is_full, almost_full, almost_empty, overflow, underflow;

    logic       enq5 = 1'b0, deq5 = 1'b0;
    logic [7:0] din5 = '0;
    logic [7:0] dout5;
    logic [2:0] cnt5;
    logic       emp5, full5, af5, ae5, ovf5, udf5;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    param_queue #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2)) u_dut (
        .clk(clk), .rst(rst), .enqueue(enqueue), .dequeue(dequeue), .peek(peek),
        .clear_err(clear_err), .data_in(data_in), .data_out(data_out), .count(count),
        .is_empty(is_empty), .is_full(is_full), .almost_full(almost_full),
        .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
    );

    param_queue #(.WIDTH(8), .DEPTH(5), .AF_THRESH(3), .AE_THRESH(2)) u_dut5 (
        .clk(clk), .rst(rst), .enqueue(enq5), .dequeue(deq5), .peek(1'b0),
        .clear_err(1'b0), .data_in(din5), .data_out(dout5), .count(cnt5),
        .is_empty(emp5), .is_full(full5), .almost_full(af5),
        .almost_empty(ae5), .overflow(ovf5), .underflow(udf5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock on the 8-deep queue: drive the command, take the edge, then sample 1ns later.
    task automatic cyc(input logic e, input logic d, input logic p, input logic c,
                       input logic [7:0] din);
        enqueue = e; dequeue = d; peek = p; clear_err = c; data_in = din;
        @(posedge clk);
        #1;
        enqueue = 1'b0; dequeue = 1'b0; peek = 1'b0; clear_err = 1'b0;
    endtask

    task automatic cyc5(input logic e, input logic d, input logic [7:0] din);
        enq5 = e; deq5 = d; din5 = din;
        @(posedge clk);
        #1;
        enq5 = 1'b0; deq5 = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_q [$];

        // Reset state
        #2;
        chk("rst_count", count, 0);
        chk("rst_empty", is_empty, 1);
        chk("rst_dout", data_out, 0);
        chk("rst_ae", almost_empty, 1);
        chk("rst_ovf", overflow, 0);
        chk("rst_udf", underflow, 0);
        @(posedge clk); #3; rst = 1'b1;
        @(posedge clk); #1;

        // 1: enqueue four, peek, dequeue four
        cyc(1, 0, 0, 0, 8'h11);
        cyc(1, 0, 0, 0, 8'h22);
        cyc(1, 0, 0, 0, 8'h33);
        cyc(1, 0, 0, 0, 8'h44);
        chk("t1_count4", count, 4);
        chk("t1_not_empty", is_empty, 0);
        chk("t1_not_ae", almost_empty, 0);
        cyc(0, 0, 1, 0, 8'h00);
        chk("t1_peek_dout", data_out, 8'h11);
        chk("t1_peek_count", count, 4);
        cyc(0, 1, 0, 0, 8'h00); chk("t1_deq0", data_out, 8'h11); chk("t1_cnt3", count, 3);
        cyc(0, 1, 0, 0, 8'h00); chk("t1_deq1", data_out, 8'h22);
        chk("t1_ae_at2", almost_empty, 1);
        cyc(0, 1, 0, 0, 8'h00); chk("t1_deq2", data_out, 8'h33);
        cyc(0, 1, 0, 0, 8'h00); chk("t1_deq3", data_out, 8'h44);
        chk("t1_empty", is_empty, 1);
        chk("t1_count0", count, 0);

        // 2: underflow, then clear
        cyc(0, 1, 0, 0, 8'h00);
        chk("t2_udf", underflow, 1);
        chk("t2_dout_hold", data_out, 8'h44);
        chk("t2_count", count, 0);
        cyc(0, 0, 1, 0, 8'h00);
        chk("t2_peek_empty_hold", data_out, 8'h44);
        chk("t2_peek_empty_noerr", overflow, 0);
        cyc(0, 0, 0, 1, 8'h00);
        chk("t2_udf_clr", underflow, 0);
        // A dequeue on empty in the same cycle as clear_err: the new event wins
        cyc(0, 1, 0, 1, 8'h00);
        chk("t2_clr_vs_evt", underflow, 1);
        cyc(0, 0, 0, 1, 8'h00);
        chk("t2_udf_clr2", underflow, 0);

        // 3: fill 55..CC, overflow on DD, drain in order
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 0, 0, 8'h55 + 8'(i * 8'h11));
            if (i == 4) chk("t3_af_at5", almost_full, 0);
            if (i == 5) chk("t3_af_at6", almost_full, 1);
        end
        chk("t3_full", is_full, 1);
        chk("t3_count8", count, 8);
        cyc(1, 0, 0, 0, 8'hDD);
        chk("t3_ovf", overflow, 1);
        chk("t3_count_after_ovf", count, 8);
        cyc(1, 0, 0, 1, 8'hDD);
        chk("t3_ovf_evt_wins", overflow, 1);
        cyc(0, 0, 0, 1, 8'h00);
        chk("t3_ovf_clr", overflow, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 1, 0, 8'h00);
            chk($sformatf("t3_drain%0d", i), data_out, 8'h55 + 8'(i * 8'h11));
        end
        chk("t3_empty", is_empty, 1);

        // Enqueue + dequeue on empty: only the write happens, underflow set, dout holds
        cyc(1, 1, 0, 0, 8'h5A);
        chk("t3b_count1", count, 1);
        chk("t3b_udf", underflow, 1);
        chk("t3b_dout_hold", data_out, 8'hCC);
        cyc(0, 1, 0, 1, 8'h00);
        chk("t3b_dout", data_out, 8'h5A);
        chk("t3b_udf_clr", underflow, 0);

        // 4: full queue, simultaneous enqueue EE + dequeue
        for (int i = 1; i <= 8; i++) cyc(1, 0, 0, 0, 8'(i));
        cyc(1, 1, 0, 0, 8'hEE);
        chk("t4_dout", data_out, 8'h01);
        chk("t4_count8", count, 8);
        chk("t4_no_ovf", overflow, 0);
        for (int i = 2; i <= 8; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'hEE);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 0, 0, 8'h00);
            chk($sformatf("t4_drain%0d", i), data_out, exp_q.pop_front());
        end
        chk("t4_empty", is_empty, 1);

        // 5: DEPTH=5 wrap with count held at 3
        for (int i = 0; i < 3; i++) cyc5(1, 0, 8'(i));
        chk("t5_count3", cnt5, 3);
        for (int i = 0; i < 20; i++) begin
            cyc5(1, 1, 8'(i + 3));
            chk($sformatf("t5_dout%0d", i), dout5, 8'(i));
            chk($sformatf("t5_cnt%0d", i), cnt5, 3);
        end

        // 6: asynchronous reset mid-stream with count=5
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 8'h31 + 8'(i));
        cyc(1, 0, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 8'h00);
        chk("t6_ovf_pre", overflow, 1);
        cyc(1, 1, 0, 0, 8'h00);
        cyc(0, 1, 0, 0, 8'h00);
        cyc(0, 1, 0, 0, 8'h00);
        cyc(0, 1, 0, 0, 8'h00);
        chk("t6_pre_count", count, 5);
        chk("t6_pre_dout", data_out, 8'h34);
        #3; rst = 1'b0; #1;
        chk("t6_count", count, 0);
        chk("t6_dout", data_out, 0);
        chk("t6_empty", is_empty, 1);
        chk("t6_ovf", overflow, 0);
        chk("t6_cnt5", cnt5, 0);
        #2; rst = 1'b1;
        @(posedge clk); #1;
        cyc(1, 0, 0, 0, 8'h7A);
        chk("t6_count1", count, 1);
        cyc(0, 1, 0, 0, 8'h00);
        chk("t6_dout_7a", data_out, 8'h7A);
        chk("t6_final_empty", is_empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
